// File: rtl/lc3b_types_pkg.sv
// Shared LC-3b memory-system types: cache-line widths and the CPU-side
// wishbone port identifiers used by the interconnect.
package lc3b_types;

    localparam int WB_DATA_W = 128;
    localparam int WB_ADR_W  = 12;
    localparam int WB_SEL_W  = 16;

    typedef logic [WB_DATA_W-1:0] lc3b_line;
    typedef logic [WB_ADR_W-1:0]  lc3b_line_adr;
    typedef logic [WB_SEL_W-1:0]  lc3b_line_sel;

    typedef enum logic {
        PORT_INSTRUCTION = 1'b0,
        PORT_DATA        = 1'b1
    } lc3b_wb_port;

endpackage

// File: rtl/wishbone.sv
// Line-granular wishbone bundle. ADR is a 16-byte line address, SEL is a
// per-byte enable across the line.
interface wishbone;

    logic                   CYC;
    logic                   STB;
    logic                   WE;
    lc3b_types::lc3b_line_adr ADR;
    lc3b_types::lc3b_line_sel SEL;
    lc3b_types::lc3b_line   DAT_M;
    lc3b_types::lc3b_line   DAT_S;
    logic                   ACK;
    logic                   RTY;

    modport master (
        output CYC, STB, WE, ADR, SEL, DAT_M,
        input  DAT_S, ACK, RTY
    );

    modport slave (
        input  CYC, STB, WE, ADR, SEL, DAT_M,
        output DAT_S, ACK, RTY
    );

endinterface

// File: rtl/wishbone_arbiter.sv
// Two-master round-robin arbiter joining the CPU fetch and load/store
// wishbone ports onto the single physical memory port. Requests are passed
// through unbuffered; one idle turnaround cycle separates transfers.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | memory port quiet; arbitrate any pending requests
// GRANT_I | instruction port owns the memory bus until ACK/RTY or abort
// GRANT_D | data port owns the memory bus until ACK/RTY or abort
module wishbone_arbiter
    import lc3b_types::*;
(
    input  logic   clk,
    input  logic   rst,
    wishbone.slave  instruction_wishbone,
    wishbone.slave  data_wishbone,
    wishbone.master memory_wishbone
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    lc3b_wb_port last_grant;
    logic        req_i;
    logic        req_d;

    // State register; last_grant remembers who was served on each new grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= PORT_INSTRUCTION;
        end else begin
            state <= state_next;
            if (state == IDLE && state_next == GRANT_I) begin
                last_grant <= PORT_INSTRUCTION;
            end else if (state == IDLE && state_next == GRANT_D) begin
                last_grant <= PORT_DATA;
            end
        end
    end

    // Arbitration, next-state and combinational bus routing.
    always_comb begin
        state_next = state;
        req_i      = instruction_wishbone.CYC & instruction_wishbone.STB;
        req_d      = data_wishbone.CYC & data_wishbone.STB;

        memory_wishbone.CYC   = 1'b0;
        memory_wishbone.STB   = 1'b0;
        memory_wishbone.WE    = 1'b0;
        memory_wishbone.ADR   = '0;
        memory_wishbone.SEL   = '0;
        memory_wishbone.DAT_M = '0;

        // Read data fans out to both ports; only ACK/RTY qualify it.
        instruction_wishbone.DAT_S = memory_wishbone.DAT_S;
        instruction_wishbone.ACK   = 1'b0;
        instruction_wishbone.RTY   = 1'b0;
        data_wishbone.DAT_S        = memory_wishbone.DAT_S;
        data_wishbone.ACK          = 1'b0;
        data_wishbone.RTY          = 1'b0;

        case (state)
            IDLE: begin
                if (req_i && req_d) begin
                    state_next = (last_grant == PORT_INSTRUCTION) ? GRANT_D : GRANT_I;
                end else if (req_i) begin
                    state_next = GRANT_I;
                end else if (req_d) begin
                    state_next = GRANT_D;
                end
            end

            GRANT_I: begin
                memory_wishbone.CYC      = instruction_wishbone.CYC;
                memory_wishbone.STB      = instruction_wishbone.STB;
                memory_wishbone.WE       = instruction_wishbone.WE;
                memory_wishbone.ADR      = instruction_wishbone.ADR;
                memory_wishbone.SEL      = instruction_wishbone.SEL;
                memory_wishbone.DAT_M    = instruction_wishbone.DAT_M;
                instruction_wishbone.ACK = memory_wishbone.ACK;
                instruction_wishbone.RTY = memory_wishbone.RTY;
                // Dropping CYC without a response is treated as an abort.
                if (memory_wishbone.ACK || memory_wishbone.RTY || !instruction_wishbone.CYC) begin
                    state_next = IDLE;
                end
            end

            GRANT_D: begin
                memory_wishbone.CYC   = data_wishbone.CYC;
                memory_wishbone.STB   = data_wishbone.STB;
                memory_wishbone.WE    = data_wishbone.WE;
                memory_wishbone.ADR   = data_wishbone.ADR;
                memory_wishbone.SEL   = data_wishbone.SEL;
                memory_wishbone.DAT_M = data_wishbone.DAT_M;
                data_wishbone.ACK     = memory_wishbone.ACK;
                data_wishbone.RTY     = memory_wishbone.RTY;
                if (memory_wishbone.ACK || memory_wishbone.RTY || !data_wishbone.CYC) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // Reset kills an in-flight cycle immediately, before the state
        // register has had a chance to return to IDLE.
        if (rst) begin
            memory_wishbone.CYC      = 1'b0;
            memory_wishbone.STB      = 1'b0;
            instruction_wishbone.ACK = 1'b0;
            instruction_wishbone.RTY = 1'b0;
            data_wishbone.ACK        = 1'b0;
            data_wishbone.RTY        = 1'b0;
        end
    end

endmodule

// File: tb/tb_wishbone_arbiter.sv
// Scoreboard bench for wishbone_arbiter: stimulus pushes expected memory
// grants and port responses; a negedge monitor pops and compares them.
module tb_wishbone_arbiter;
    import lc3b_types::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    wishbone ifc_i ();
    wishbone ifc_d ();
    wishbone ifc_m ();

    wishbone_arbiter dut (
        .clk                  (clk),
        .rst                  (rst),
        .instruction_wishbone (ifc_i),
        .data_wishbone        (ifc_d),
        .memory_wishbone      (ifc_m)
    );

    typedef struct packed {
        logic         we;
        lc3b_line_adr adr;
        lc3b_line_sel sel;
        lc3b_line     dat_m;
    } grant_t;

    typedef struct packed {
        logic     ack;
        logic     rty;
        lc3b_line dat;
    } resp_t;

    grant_t exp_grant[$];
    resp_t  exp_resp_i[$];
    resp_t  exp_resp_d[$];

    int     n_tests = 0;
    int     n_fail  = 0;
    logic   prev_stb = 1'b0;
    grant_t mon_g;
    resp_t  mon_r;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [127:0] act);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got %0h, required no event", name, act);
    endtask

    // Monitor: compare each new memory grant and each port response.
    always @(negedge clk) begin
        if (ifc_m.CYC && ifc_m.STB && !prev_stb) begin
            if (exp_grant.size() == 0) begin
                unexpected("unexpected_grant", 128'(ifc_m.ADR));
            end else begin
                mon_g = exp_grant.pop_front();
                check("grant_adr", 128'(ifc_m.ADR), 128'(mon_g.adr));
                check("grant_we", 128'(ifc_m.WE), 128'(mon_g.we));
                check("grant_sel", 128'(ifc_m.SEL), 128'(mon_g.sel));
                check("grant_dat_m", ifc_m.DAT_M, mon_g.dat_m);
            end
        end
        prev_stb = ifc_m.CYC && ifc_m.STB;

        if (ifc_i.ACK || ifc_i.RTY) begin
            if (exp_resp_i.size() == 0) begin
                unexpected("unexpected_instr_resp", 128'({ifc_i.ACK, ifc_i.RTY}));
            end else begin
                mon_r = exp_resp_i.pop_front();
                check("instr_ack", 128'(ifc_i.ACK), 128'(mon_r.ack));
                check("instr_rty", 128'(ifc_i.RTY), 128'(mon_r.rty));
                check("instr_dat_s", ifc_i.DAT_S, mon_r.dat);
            end
        end

        if (ifc_d.ACK || ifc_d.RTY) begin
            if (exp_resp_d.size() == 0) begin
                unexpected("unexpected_data_resp", 128'({ifc_d.ACK, ifc_d.RTY}));
            end else begin
                mon_r = exp_resp_d.pop_front();
                check("data_ack", 128'(ifc_d.ACK), 128'(mon_r.ack));
                check("data_rty", 128'(ifc_d.RTY), 128'(mon_r.rty));
                check("data_dat_s", ifc_d.DAT_S, mon_r.dat);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic drive_i(input logic on, input logic we, input lc3b_line_adr adr,
                           input lc3b_line_sel sel, input lc3b_line dat);
        ifc_i.CYC   = on;
        ifc_i.STB   = on;
        ifc_i.WE    = we;
        ifc_i.ADR   = adr;
        ifc_i.SEL   = sel;
        ifc_i.DAT_M = dat;
    endtask

    task automatic drive_d(input logic on, input logic we, input lc3b_line_adr adr,
                           input lc3b_line_sel sel, input lc3b_line dat);
        ifc_d.CYC   = on;
        ifc_d.STB   = on;
        ifc_d.WE    = we;
        ifc_d.ADR   = adr;
        ifc_d.SEL   = sel;
        ifc_d.DAT_M = dat;
    endtask

    task automatic mem_resp(input logic ack, input logic rty, input lc3b_line dat);
        ifc_m.ACK   = ack;
        ifc_m.RTY   = rty;
        ifc_m.DAT_S = dat;
    endtask

    initial begin
        rst = 1'b1;
        drive_i(1'b0, 1'b0, '0, '0, '0);
        drive_d(1'b0, 1'b0, '0, '0, '0);
        mem_resp(1'b0, 1'b0, '0);
        repeat (2) next_cycle();
        mid();
        check("rst_mem_cyc", 128'(ifc_m.CYC), 128'(0));
        check("rst_mem_stb", 128'(ifc_m.STB), 128'(0));

        // Contention straight out of reset: data first, then instruction.
        next_cycle();
        rst = 1'b0;
        drive_i(1'b1, 1'b0, 12'h100, 16'hFFFF, '0);
        drive_d(1'b1, 1'b1, 12'h200, 16'h00FF, {16{8'h55}});
        exp_grant.push_back('{1'b1, 12'h200, 16'h00FF, {16{8'h55}}});
        exp_grant.push_back('{1'b0, 12'h100, 16'hFFFF, 128'h0});
        mid();
        check("idle_stb", 128'(ifc_m.STB), 128'(0));
        check("idle_adr", 128'(ifc_m.ADR), 128'(0));
        check("idle_sel", 128'(ifc_m.SEL), 128'(0));
        check("idle_we", 128'(ifc_m.WE), 128'(0));
        check("idle_dat_m", ifc_m.DAT_M, 128'h0);
        next_cycle();
        mid();
        check("contend_data_first", 128'(ifc_m.ADR), 128'(12'h200));
        next_cycle();
        mem_resp(1'b1, 1'b0, {16{8'h3C}});
        exp_resp_d.push_back('{1'b1, 1'b0, {16{8'h3C}}});
        mid();
        check("contend_instr_held", 128'(ifc_i.ACK), 128'(0));
        next_cycle();
        mem_resp(1'b0, 1'b0, '0);
        drive_d(1'b0, 1'b0, '0, '0, '0);
        mid();
        check("contend_turnaround", 128'(ifc_m.STB), 128'(0));
        next_cycle();
        mid();
        check("contend_instr_grant", 128'(ifc_m.ADR), 128'(12'h100));
        next_cycle();
        mem_resp(1'b1, 1'b0, {16{8'hC3}});
        exp_resp_i.push_back('{1'b1, 1'b0, {16{8'hC3}}});
        next_cycle();
        mem_resp(1'b0, 1'b0, '0);
        drive_i(1'b0, 1'b0, '0, '0, '0);

        // Instruction read at 0x010, ACK in the fourth grant cycle.
        next_cycle();
        drive_i(1'b1, 1'b0, 12'h010, 16'hFFFF, '0);
        exp_grant.push_back('{1'b0, 12'h010, 16'hFFFF, 128'h0});
        mid();
        check("read_cycle0_stb", 128'(ifc_m.STB), 128'(0));
        for (int c = 1; c <= 3; c++) begin
            next_cycle();
            mid();
            check("read_stb_held", 128'(ifc_m.STB), 128'(1));
            check("read_no_early_ack", 128'(ifc_i.ACK), 128'(0));
        end
        next_cycle();
        mem_resp(1'b1, 1'b0, {16{8'hA5}});
        exp_resp_i.push_back('{1'b1, 1'b0, {16{8'hA5}}});
        mid();
        check("read_cycle4_stb", 128'(ifc_m.STB), 128'(1));
        check("read_other_ack", 128'(ifc_d.ACK), 128'(0));
        next_cycle();
        mem_resp(1'b0, 1'b0, '0);
        drive_i(1'b0, 1'b0, '0, '0, '0);
        mid();
        check("read_cycle5_idle", 128'(ifc_m.STB), 128'(0));

        // Data write at 0x7FF passes through untouched.
        next_cycle();
        drive_d(1'b1, 1'b1, 12'h7FF, 16'h000F, 128'h1234);
        exp_grant.push_back('{1'b1, 12'h7FF, 16'h000F, 128'h1234});
        next_cycle();
        mid();
        check("write_we", 128'(ifc_m.WE), 128'(1));
        next_cycle();
        mem_resp(1'b1, 1'b0, 128'h0BAD);
        exp_resp_d.push_back('{1'b1, 1'b0, 128'h0BAD});
        mid();
        check("write_ack_mirror", 128'(ifc_d.ACK), 128'(1));
        check("write_instr_ack", 128'(ifc_i.ACK), 128'(0));
        next_cycle();
        mem_resp(1'b0, 1'b0, '0);
        drive_d(1'b0, 1'b0, '0, '0, '0);

        // Retry to data, which keeps requesting and is granted again.
        next_cycle();
        drive_d(1'b1, 1'b0, 12'h0AA, 16'hFFFF, '0);
        exp_grant.push_back('{1'b0, 12'h0AA, 16'hFFFF, 128'h0});
        exp_grant.push_back('{1'b0, 12'h0AA, 16'hFFFF, 128'h0});
        next_cycle();
        mem_resp(1'b0, 1'b1, {16{8'h99}});
        exp_resp_d.push_back('{1'b0, 1'b1, {16{8'h99}}});
        mid();
        check("rty_pass", 128'(ifc_d.RTY), 128'(1));
        check("rty_instr_masked", 128'(ifc_i.RTY), 128'(0));
        next_cycle();
        mem_resp(1'b0, 1'b0, '0);
        mid();
        check("rty_turnaround", 128'(ifc_m.STB), 128'(0));
        next_cycle();
        mid();
        check("rty_regrant", 128'(ifc_m.STB), 128'(1));
        next_cycle();
        mem_resp(1'b1, 1'b0, {16{8'h77}});
        exp_resp_d.push_back('{1'b1, 1'b0, {16{8'h77}}});
        next_cycle();
        mem_resp(1'b0, 1'b0, '0);
        drive_d(1'b0, 1'b0, '0, '0, '0);

        // Instruction aborts; data request arriving mid-grant is served next.
        next_cycle();
        drive_i(1'b1, 1'b0, 12'h033, 16'hFFFF, '0);
        exp_grant.push_back('{1'b0, 12'h033, 16'hFFFF, 128'h0});
        exp_grant.push_back('{1'b0, 12'h044, 16'hFFFF, 128'h0});
        next_cycle();
        drive_d(1'b1, 1'b0, 12'h044, 16'hFFFF, '0);
        mid();
        check("abort_instr_adr", 128'(ifc_m.ADR), 128'(12'h033));
        check("abort_data_held", 128'(ifc_d.ACK), 128'(0));
        next_cycle();
        drive_i(1'b0, 1'b0, '0, '0, '0);
        mid();
        check("abort_cyc_pass", 128'(ifc_m.CYC), 128'(0));
        next_cycle();
        mid();
        check("abort_idle", 128'(ifc_m.STB), 128'(0));
        next_cycle();
        mid();
        check("abort_data_stb", 128'(ifc_m.STB), 128'(1));
        check("abort_data_adr", 128'(ifc_m.ADR), 128'(12'h044));
        next_cycle();
        mem_resp(1'b1, 1'b0, {16{8'h11}});
        exp_resp_d.push_back('{1'b1, 1'b0, {16{8'h11}}});
        next_cycle();
        mem_resp(1'b0, 1'b0, '0);
        drive_d(1'b0, 1'b0, '0, '0, '0);

        // Reset during a data grant; a late ACK must reach nobody.
        next_cycle();
        drive_d(1'b1, 1'b0, 12'h0F0, 16'hFFFF, '0);
        exp_grant.push_back('{1'b0, 12'h0F0, 16'hFFFF, 128'h0});
        next_cycle();
        mid();
        check("rstmid_granted", 128'(ifc_m.STB), 128'(1));
        next_cycle();
        rst = 1'b1;
        mid();
        check("rstmid_cyc", 128'(ifc_m.CYC), 128'(0));
        check("rstmid_stb", 128'(ifc_m.STB), 128'(0));
        next_cycle();
        rst = 1'b0;
        drive_d(1'b0, 1'b0, '0, '0, '0);
        mem_resp(1'b1, 1'b0, {16{8'hEE}});
        mid();
        check("stray_ack_data", 128'(ifc_d.ACK), 128'(0));
        check("stray_ack_instr", 128'(ifc_i.ACK), 128'(0));
        check("stray_ack_stb", 128'(ifc_m.STB), 128'(0));
        next_cycle();
        mem_resp(1'b0, 1'b0, '0);

        // Reset restores the round-robin pointer: data wins again.
        drive_i(1'b1, 1'b0, 12'h111, 16'hFFFF, '0);
        drive_d(1'b1, 1'b0, 12'h222, 16'hFFFF, '0);
        exp_grant.push_back('{1'b0, 12'h222, 16'hFFFF, 128'h0});
        exp_grant.push_back('{1'b0, 12'h111, 16'hFFFF, 128'h0});
        next_cycle();
        mid();
        check("post_rst_data_first", 128'(ifc_m.ADR), 128'(12'h222));
        next_cycle();
        mem_resp(1'b1, 1'b0, {16{8'h22}});
        exp_resp_d.push_back('{1'b1, 1'b0, {16{8'h22}}});
        next_cycle();
        mem_resp(1'b0, 1'b0, '0);
        drive_d(1'b0, 1'b0, '0, '0, '0);
        next_cycle();
        mid();
        check("post_rst_instr_next", 128'(ifc_m.ADR), 128'(12'h111));
        next_cycle();
        mem_resp(1'b1, 1'b0, {16{8'h44}});
        exp_resp_i.push_back('{1'b1, 1'b0, {16{8'h44}}});
        next_cycle();
        mem_resp(1'b0, 1'b0, '0);
        drive_i(1'b0, 1'b0, '0, '0, '0);
        repeat (2) next_cycle();

        check("pending_grants", 128'(exp_grant.size()), 128'(0));
        check("pending_instr_resp", 128'(exp_resp_i.size()), 128'(0));
        check("pending_data_resp", 128'(exp_resp_d.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
